// File: rtl/morph_stream_stage.sv
// Streaming 3x3 binary morphology stage (bypass / erode / dilate / edge) over a
// row-major 1-bit raster, with internal line buffers, border padding and flush.
module morph_stream_stage #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 256,
    parameter int CW    = 8,
    parameter int RW    = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] mode,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic       in_pixel,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_pixel,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
    typedef enum logic [1:0] {M_BYPASS = 2'b00, M_ERODE = 2'b01,
                              M_DILATE = 2'b10, M_EDGE  = 2'b11} mode_t;

    localparam int AW = $clog2(IMG_W);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [CW:0]   FLUSH_LAST = (CW + 1)'(IMG_W);

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
    logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
    logic [CW:0]   flush_cnt_q, flush_cnt_d;
    logic [2:0]    win_top_q, win_top_d, win_mid_q, win_mid_d, win_bot_q, win_bot_d;
    logic          in_ready_q, in_ready_d, busy_q, busy_d;
    logic          out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_pixel_q, out_pixel_d;

    logic          lb0_mem [IMG_W];
    logic          lb1_mem [IMG_W];
    logic [AW-1:0] lb_addr;
    logic          lb0_rd, lb1_rd;

    logic accept, run_emit;
    logic restart, beat, emit, lb_we, beat_pix, last_px;
    logic [2:0] pad_col, pad_top, pad_bot;
    logic ero, dil, result;

    assign accept   = in_valid & in_ready_q;
    // Beat index >= IMG_W+1 means the window center is a real output pixel.
    assign run_emit = (in_row_q >= RW'(2)) || ((in_row_q == RW'(1)) && (in_col_q != '0));

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        restart  = 1'b0;
        beat     = 1'b0;
        emit     = 1'b0;
        lb_we    = 1'b0;
        beat_pix = 1'b0;
        last_px  = 1'b0;
        unique case (state_q)
            S_IDLE:  restart = accept & in_sof;
            S_RUN: begin
                if (accept) begin
                    if (in_sof) begin
                        restart = 1'b1;
                    end else begin
                        beat     = 1'b1;
                        lb_we    = 1'b1;
                        beat_pix = in_pixel;
                        emit     = run_emit;
                        last_px  = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
                    end
                end
            end
            S_FLUSH: begin
                beat = 1'b1;
                emit = 1'b1;
            end
            default: ;
        endcase
        if (restart) begin
            beat     = 1'b1;
            lb_we    = 1'b1;
            beat_pix = in_pixel;
        end
    end

    assign lb_addr = restart ? '0 : in_col_q[AW-1:0];
    assign lb0_rd  = lb0_mem[lb_addr];
    assign lb1_rd  = lb1_mem[lb_addr];

    // NOTE: line buffers carry no reset; border padding masks any stale content.
    always_ff @(posedge clock) begin
        if (lb_we) begin
            lb0_mem[lb_addr] <= beat_pix;
            lb1_mem[lb_addr] <= lb0_rd;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        in_col_d    = in_col_q;
        in_row_d    = in_row_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        flush_cnt_d = flush_cnt_q;
        win_top_d   = win_top_q;
        win_mid_d   = win_mid_q;
        win_bot_d   = win_bot_q;

        // Bit 0 is the newest column (c+1), bit 2 the oldest (c-1).
        if (beat) begin
            win_top_d = {win_top_q[1:0], lb1_rd};
            win_mid_d = {win_mid_q[1:0], lb0_rd};
            win_bot_d = {win_bot_q[1:0], beat_pix};
        end

        pad_col = {out_col_q == '0, 1'b0, out_col_q == COL_LAST};
        pad_top = pad_col | {3{out_row_q == '0}};
        pad_bot = pad_col | {3{out_row_q == ROW_LAST}};
        ero = (&(win_top_d | pad_top)) & (&(win_mid_d | pad_col)) & (&(win_bot_d | pad_bot));
        dil = (|(win_top_d & ~pad_top)) | (|(win_mid_d & ~pad_col)) | (|(win_bot_d & ~pad_bot));
        unique case (mode_q)
            M_BYPASS: result = win_mid_d[1];
            M_ERODE:  result = ero;
            M_DILATE: result = dil;
            M_EDGE:   result = ero ^ dil;
            default:  result = 1'b0;
        endcase

        out_valid_d = emit;
        out_sof_d   = emit && (out_row_q == '0) && (out_col_q == '0);
        out_pixel_d = emit ? result : out_pixel_q;

        if (restart) begin
            state_d   = S_RUN;
            mode_d    = mode_t'(mode);
            in_col_d  = CW'(1);
            in_row_d  = '0;
            out_col_d = '0;
            out_row_d = '0;
        end else begin
            if (beat) begin
                if (in_col_q == COL_LAST) begin
                    in_col_d = '0;
                    in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
                end else begin
                    in_col_d = in_col_q + CW'(1);
                end
            end
            if (emit) begin
                if (out_col_q == COL_LAST) begin
                    out_col_d = '0;
                    out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
                end else begin
                    out_col_d = out_col_q + CW'(1);
                end
            end
            if (last_px) begin
                state_d     = S_FLUSH;
                flush_cnt_d = '0;
            end
            if (state_q == S_FLUSH) begin
                flush_cnt_d = flush_cnt_q + (CW + 1)'(1);
                if (flush_cnt_q == FLUSH_LAST) state_d = S_IDLE;
            end
        end

        in_ready_d = (state_d != S_FLUSH);
        busy_d     = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mode_q      <= M_BYPASS;
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            flush_cnt_q <= '0;
            win_top_q   <= '0;
            win_mid_q   <= '0;
            win_bot_q   <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_pixel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            flush_cnt_q <= flush_cnt_d;
            win_top_q   <= win_top_d;
            win_mid_q   <= win_mid_d;
            win_bot_q   <= win_bot_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_pixel_q <= out_pixel_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_morph_stream_stage.sv
// Directed bench for morph_stream_stage on an 8x4 image: a spatial reference
// model fills a scoreboard queue, a negedge monitor pops and compares outputs.
module tb_morph_stream_stage;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] mode;
    logic       in_valid, in_sof, in_pixel;
    logic       in_ready, out_valid, out_sof, out_pixel, busy;

    typedef struct {
        logic pix;
        logic sof;
        int   k;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   acc_cnt = 0;
    int   acc_base = 0;
    int   out_seen = 0;
    int   ones_seen = 0;

    morph_stream_stage #(.IMG_W(W), .IMG_H(H), .CW(3), .RW(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_pixel (out_pixel),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Direct spatial definition: out-of-image neighbours are skipped, which is
    // padding 1 for the AND and padding 0 for the OR.
    function automatic logic model(input logic [N-1:0] f, input logic [1:0] m, input int k);
        int r = k / W;
        int c = k % W;
        logic ero = 1'b1;
        logic dil = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                    ero &= f[rr * W + cc];
                    dil |= f[rr * W + cc];
                end
            end
        end
        case (m)
            2'b00:   return f[k];
            2'b01:   return ero;
            2'b10:   return dil;
            default: return ero ^ dil;
        endcase
    endfunction

    task automatic push_exp(input logic [N-1:0] f, input logic [1:0] m, input int count);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            e.pix = model(f, m, k);
            e.sof = (k == 0);
            e.k   = k;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input logic sof, input logic pix);
        logic acc;
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix;
        acc      = in_ready;
        @(posedge clock);
        if (acc) acc_cnt++;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [N-1:0] f, input int npix, input bit gaps,
                              input logic [1:0] mode_mid);
        acc_base = acc_cnt;
        for (int i = 0; i < npix; i++) begin
            if (gaps && i != 0 && $urandom_range(1) == 1) idle($urandom_range(1, 2));
            drive(i == 0, f[i]);
            if (i == 0) mode = mode_mid;
        end
    endtask

    task automatic wait_idle(input string tag);
        @(negedge clock);
        for (int n = 0; n < 200 && busy; n++) @(negedge clock);
        @(negedge clock);
        check({tag, " drain"}, busy, 0);
        check({tag, " scoreboard empty"}, exp_q.size(), 0);
    endtask

    task automatic run_frame(input string tag, input logic [N-1:0] f, input logic [1:0] m,
                             input int ones_exp);
        mode      = m;
        out_seen  = 0;
        ones_seen = 0;
        push_exp(f, m, N);
        send_frame(f, N, 1'b0, m);
        idle(0);
        wait_idle(tag);
        check({tag, " outputs"}, out_seen, N);
        check({tag, " ones"}, ones_seen, ones_exp);
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected output", out_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("pix k=%0d", mon_e.k), out_pixel, mon_e.pix);
                check($sformatf("sof k=%0d", mon_e.k), out_sof, mon_e.sof);
                if (out_sof) check("first output latency", acc_cnt - acc_base, W + 2);
                out_seen++;
                if (out_pixel) ones_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] fa, fb, fc;
        int low;

        reset_n  = 1'b0;
        mode     = 2'b00;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = 1'b0;
        repeat (2) @(negedge clock);
        check("reset out_valid", out_valid, 0);
        check("reset out_sof", out_sof, 0);
        check("reset out_pixel", out_pixel, 0);
        check("reset busy", busy, 0);
        check("reset in_ready", in_ready, 1);
        reset_n = 1'b1;
        @(negedge clock);

        // Accepts without in_sof in IDLE are dropped.
        out_seen = 0;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
        idle(12);
        check("idle drop busy", busy, 0);
        check("idle drop outputs", out_seen, 0);

        // Bypass with p[i]=i[0]; an in_sof offered during FLUSH must be ignored.
        mode      = 2'b00;
        out_seen  = 0;
        ones_seen = 0;
        push_exp(32'hAAAA_AAAA, 2'b00, N);
        send_frame(32'hAAAA_AAAA, N, 1'b0, 2'b00);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_pixel = 1'b1;
        @(negedge clock);
        check("flush in_ready", in_ready, 0);
        check("flush busy", busy, 1);
        repeat (2) @(negedge clock);
        idle(0);
        wait_idle("bypass");
        check("bypass outputs", out_seen, N);
        check("bypass ones", ones_seen, 16);

        run_frame("erode ones", {N{1'b1}}, 2'b01, 32);
        run_frame("erode hole", ~(32'd1 << 11), 2'b01, 23);
        run_frame("dilate corner", 32'd1, 2'b10, 4);
        run_frame("dilate right edge", 32'd1 << 15, 2'b10, 6);
        // (0,3) and (1,3) erode to 1: top padding counts as ones.
        run_frame("edge block", 32'h001C_1C1C, 2'b11, 18);

        // Random gaps, mode change after sof ignored, then flush length.
        fa        = $urandom;
        mode      = 2'b10;
        out_seen  = 0;
        push_exp(fa, 2'b10, N);
        send_frame(fa, N, 1'b1, 2'b01);
        idle(0);
        low = 0;
        while (!in_ready && low < 50) begin
            low++;
            @(negedge clock);
        end
        check("flush in_ready low cycles", low, W + 1);
        check("busy after flush", busy, 0);
        wait_idle("gaps");
        check("gaps outputs", out_seen, N);

        // Early sof after 12 pixels aborts frame A; frame B runs in full.
        fa       = $urandom;
        fb       = $urandom;
        mode     = 2'b11;
        out_seen = 0;
        push_exp(fa, 2'b11, 12 - (W + 1));
        send_frame(fa, 12, 1'b0, 2'b11);
        mode = 2'b01;
        push_exp(fb, 2'b01, N);
        send_frame(fb, N, 1'b0, 2'b01);
        idle(0);
        wait_idle("abort");
        check("abort outputs", out_seen, 12 - (W + 1) + N);

        // Reset pulse mid-frame while outputs are streaming.
        fc       = $urandom;
        mode     = 2'b10;
        out_seen = 0;
        push_exp(fc, 2'b10, 12 - (W + 1));
        send_frame(fc, 12, 1'b0, 2'b10);
        #2;
        reset_n = 1'b0;
        idle(0);
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset out_sof", out_sof, 0);
        check("midreset out_pixel", out_pixel, 0);
        check("midreset busy", busy, 0);
        check("midreset in_ready", in_ready, 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("midreset outputs before reset", out_seen, 12 - (W + 1));
        check("midreset scoreboard empty", exp_q.size(), 0);
        fa = $urandom;
        run_frame("recovery", fa, 2'b00, $countones(fa));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
